piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in serial-out converter that sits directly downstream of the 4-bit parallel register stage and consumes its registered word.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per enabled clock, with a DONE strobe per word.
- Supports gap-free back-to-back words.
- Sends the serial stream to a bit-rate-paced link or to a downstream deserializer.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 0, bit order: 0 = bit 0 first, 1 = bit WIDTH-1 first.

Ports:
CLK  input  1  clock; all state changes on posedge.
RST  input  1  reset, asynchronous, active-high; clock CLK.
IN_DATA  input  WIDTH  parallel word from the upstream register stage.
IN_VALID  input  1  IN_DATA holds a word to be taken.
IN_READY  output  1  block can take a word this cycle.
SER_EN  input  1  bit-rate tick; the current bit advances only on cycles where this is 1.
SOUT  output  1  serial data bit, registered.
SOUT_VALID  output  1  SOUT carries a valid data bit.
BUSY  output  1  a word is being shifted out (state SHIFT).
DONE  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (RST=1, asynchronous):
  - State goes to IDLE; shift register, bit counter, SOUT, SOUT_VALID, BUSY and DONE are all 0.
  - IN_READY is held at 0 while RST is high.
- States: IDLE, SHIFT.
- Handshake: a word is accepted at a posedge where IN_VALID=1 and IN_READY=1.
- IN_READY (combinational) = (state==IDLE) OR (state==SHIFT AND cnt==WIDTH-1 AND SER_EN=1).
  - This path is combinational from SER_EN, which is intended.
- IN_VALID while IN_READY=0 is ignored. The upstream stage must hold IN_DATA/IN_VALID until it is accepted.
- IDLE:
  - SOUT=0, SOUT_VALID=0, BUSY=0.
  - On accept: load shift register with IN_DATA, cnt<=0, go to SHIFT.
- SHIFT, outputs:
  - SOUT_VALID=1, BUSY=1.
  - SOUT = shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1).
- SHIFT, latency: the first bit is on SOUT in the cycle after the accepting edge, independent of SER_EN.
- SHIFT, bit advance: on a posedge with SER_EN=1 and cnt<WIDTH-1, shift one position toward the output end (fill 0) and increment cnt.
- SHIFT, stall: with SER_EN=0, SOUT, cnt and the shift register hold indefinitely.
- Last bit (cnt==WIDTH-1 AND SER_EN=1):
  - DONE<=1 for exactly one cycle.
  - If IN_VALID=1, the new word is accepted in the same edge: reload, cnt<=0, stay in SHIFT. There is no idle gap and SOUT_VALID stays 1.
  - Otherwise go to IDLE; SOUT and SOUT_VALID return to 0 next cycle.
- Bit-cell duration: each bit is held on SOUT from one enabled edge to the next. A word therefore occupies exactly WIDTH SER_EN pulses.
- Counter: width is clog2(WIDTH) and it never wraps past WIDTH-1.
- SER_EN in IDLE has no effect.
- DONE is registered and is asserted only in the cycle after the final enabled edge.
- Reset mid-word: the in-flight word is discarded, nothing resumes, and no DONE is emitted.

Test Plan:
1. WIDTH=4, MSB_FIRST=0, IN_DATA=4'b1011 accepted, SER_EN=1 continuously.
   -> SOUT = 1,1,0,1 over 4 cycles with SOUT_VALID=1.
   -> DONE high in cycle 5, then IDLE with SOUT=0.
2. Same word, MSB_FIRST=1.
   -> SOUT = 1,0,1,1.
3. Stall: 4'b0110, SER_EN=1 only every 3rd cycle.
   -> each bit held 3 cycles; sequence 0,1,1,0; BUSY high 12 cycles.
   -> IN_VALID with 4'hF mid-word: IN_READY=0 and the word is not taken.
4. Back-to-back: 4'hA then 4'h5 with IN_VALID held, MSB_FIRST=0.
   -> 8 contiguous bits 0,1,0,1,1,0,1,0; SOUT_VALID never drops.
   -> DONE pulses after bit 4 and bit 8.
5. Reset mid-word: assert RST asynchronously after 2 bits of 4'b1101.
   -> SOUT, SOUT_VALID, BUSY and DONE are 0 immediately, with no DONE pulse.
   -> after release, IN_READY=1 and the next word 4'b0011 shifts correctly.
6. WIDTH=8, 8'h81, MSB_FIRST=0.
   -> 1,0,0,0,0,0,0,1; cnt reaches 7 and returns to IDLE.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Bus bundle for piso_serializer.
//   master : upstream register stage plus the bit-rate tick source.
//            It drives IN_DATA/IN_VALID/SER_EN and observes the rest.
//   slave  : the serializer itself.
// Signals:
//   IN_DATA    parallel word to be taken
//   IN_VALID   IN_DATA holds a word
//   IN_READY   serializer can take a word this cycle
//   SER_EN     bit-rate tick
//   SOUT       serial data bit
//   SOUT_VALID SOUT carries a data bit
//   BUSY       a word is being shifted out
//   DONE       one-cycle pulse after the last bit of a word
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             SER_EN;
    logic             SOUT;
    logic             SOUT_VALID;
    logic             BUSY;
    logic             DONE;

    modport master (
        output IN_DATA, IN_VALID, SER_EN,
        input  IN_READY, SOUT, SOUT_VALID, BUSY, DONE
    );

    modport slave (
        input  IN_DATA, IN_VALID, SER_EN,
        output IN_READY, SOUT, SOUT_VALID, BUSY, DONE
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter.
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per SER_EN tick. A DONE strobe follows each word. Back-to-back words
// are accepted on the last enabled edge, so there is no idle gap.
// Ports:
//   CLK  clock, posedge
//   RST  asynchronous, active-high reset
//   bus  piso_serializer_if slave modport. It carries IN_DATA/IN_VALID/
//        IN_READY/SER_EN/SOUT/SOUT_VALID/BUSY/DONE.
// Parameters:
//   WIDTH      word width, 2..32
//   MSB_FIRST  0 = bit 0 first, 1 = bit WIDTH-1 first
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input logic             CLK,
    input logic             RST,
    piso_serializer_if.slave bus
);
    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic last_bit;
    logic in_ready;
    logic accept;

    // The final bit is consumed on this edge. The same edge may also take a new word.
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST) && bus.SER_EN;
    assign in_ready = !RST && ((state_q == IDLE) || last_bit);
    assign accept   = bus.IN_VALID && in_ready;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = SHIFT;
            SHIFT: if (last_bit) state_d = bus.IN_VALID ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift register and bit counter
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shreg_d = bus.IN_DATA;
            cnt_d   = '0;
        end else if ((state_q == SHIFT) && bus.SER_EN && (cnt_q != LAST)) begin
            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // The outputs are registered. Each one is computed from the next state and
    // the next shift register, so that SOUT shows the loaded word's first bit
    // in the cycle right after the accepting edge.
    always_comb begin
        sout_valid_d = (state_d == SHIFT);
        busy_d       = (state_d == SHIFT);
        sout_d       = 1'b0;
        if (state_d == SHIFT) begin
            sout_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end
        done_d = last_bit;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.IN_READY   = in_ready;
    assign bus.SOUT       = sout_q;
    assign bus.SOUT_VALID = sout_valid_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer.
// Three instances are driven side by side:
//   lane 0: WIDTH=4, LSB first
//   lane 1: WIDTH=4, MSB first
//   lane 2: WIDTH=8, LSB first
// For each lane, a queue-based reference model holds the bits still to
// appear on SOUT.
module tb_piso_serializer;
    localparam int          NL     = 3;
    localparam int unsigned LW [3] = '{4, 4, 8};
    localparam bit          LM [3] = '{1'b0, 1'b1, 1'b0};

    logic        CLK;
    logic        rst;
    logic        ser_en;
    logic [31:0] in_data  [NL];
    logic        in_valid [NL];
    logic        o_ready  [NL];
    logic        o_sout   [NL];
    logic        o_svalid [NL];
    logic        o_busy   [NL];
    logic        o_done   [NL];

    piso_serializer_if #(.WIDTH(4)) if0 ();
    piso_serializer_if #(.WIDTH(4)) if1 ();
    piso_serializer_if #(.WIDTH(8)) if2 ();

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut0 (.CLK(CLK), .RST(rst), .bus(if0));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut1 (.CLK(CLK), .RST(rst), .bus(if1));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut2 (.CLK(CLK), .RST(rst), .bus(if2));

    assign if0.IN_DATA  = in_data[0][3:0];
    assign if1.IN_DATA  = in_data[1][3:0];
    assign if2.IN_DATA  = in_data[2][7:0];
    assign if0.IN_VALID = in_valid[0];
    assign if1.IN_VALID = in_valid[1];
    assign if2.IN_VALID = in_valid[2];
    assign if0.SER_EN   = ser_en;
    assign if1.SER_EN   = ser_en;
    assign if2.SER_EN   = ser_en;

    assign o_ready[0]  = if0.IN_READY;   assign o_ready[1]  = if1.IN_READY;   assign o_ready[2]  = if2.IN_READY;
    assign o_sout[0]   = if0.SOUT;       assign o_sout[1]   = if1.SOUT;       assign o_sout[2]   = if2.SOUT;
    assign o_svalid[0] = if0.SOUT_VALID; assign o_svalid[1] = if1.SOUT_VALID; assign o_svalid[2] = if2.SOUT_VALID;
    assign o_busy[0]   = if0.BUSY;       assign o_busy[1]   = if1.BUSY;       assign o_busy[2]   = if2.BUSY;
    assign o_done[0]   = if0.DONE;       assign o_done[1]   = if1.DONE;       assign o_done[2]   = if2.DONE;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: bits still to be shown on SOUT, head = current bit.
    bit          mq     [NL][$];
    bit          mdone  [NL];
    // Upstream word queues per lane; the head is presented with IN_VALID=1.
    logic [31:0] tx     [NL][$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input int lane, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s lane%0d cyc%0d: got %0h expected %0h", tag, lane, cyc, obs, exp);
    endtask

    function automatic void model_clear();
        for (int l = 0; l < NL; l++) begin
            mq[l].delete();
            mdone[l] = 1'b0;
        end
    endfunction

    task automatic push_word(input int lane, input logic [31:0] w);
        tx[lane].push_back(w & ((32'd1 << LW[lane]) - 32'd1));
    endtask

    // One clock cycle. The step is entered near a negedge with rst and ser_en
    // already set. It drives the upstream inputs, checks every lane, and then
    // advances the model across the posedge.
    task automatic step();
        bit exp_ready [NL];
        for (int l = 0; l < NL; l++) begin
            in_valid[l] = (tx[l].size() > 0);
            in_data[l]  = in_valid[l] ? tx[l][0] : $urandom;
        end
        #1;
        if (rst) model_clear();
        for (int l = 0; l < NL; l++) begin
            exp_ready[l] = !rst && ((mq[l].size() == 0) || ((mq[l].size() == 1) && ser_en));
            chk("in_ready",   l, {31'd0, o_ready[l]},  {31'd0, exp_ready[l]});
            chk("sout",       l, {31'd0, o_sout[l]},   (mq[l].size() > 0) ? {31'd0, mq[l][0]} : 32'd0);
            chk("sout_valid", l, {31'd0, o_svalid[l]}, {31'd0, mq[l].size() > 0});
            chk("busy",       l, {31'd0, o_busy[l]},   {31'd0, mq[l].size() > 0});
            chk("done",       l, {31'd0, o_done[l]},   {31'd0, mdone[l]});
        end
        @(posedge CLK);
        cyc++;
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                mq[l].delete();
                mdone[l] = 1'b0;
            end else begin
                mdone[l] = (mq[l].size() == 1) && ser_en;
                if ((mq[l].size() > 0) && ser_en) void'(mq[l].pop_front());
                if (in_valid[l] && exp_ready[l]) begin
                    for (int unsigned b = 0; b < LW[l]; b++) begin
                        mq[l].push_back(LM[l] ? in_data[l][LW[l]-1-b] : in_data[l][b]);
                    end
                    void'(tx[l].pop_front());
                end
            end
        end
        @(negedge CLK);
    endtask

    // mode 0: SER_EN always 1; mode 1: every 3rd cycle; mode 2: random
    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       ser_en = 1'b1;
                1:       ser_en = (i % 3) == 0;
                default: ser_en = ($urandom_range(0, 2) != 0);
            endcase
            step();
        end
    endtask

    initial begin
        rst    = 1'b1;
        ser_en = 1'b0;
        for (int l = 0; l < NL; l++) begin
            in_valid[l] = 1'b0;
            in_data[l]  = '0;
            mdone[l]    = 1'b0;
        end
        @(negedge CLK);
        // Hold reset with a word waiting: nothing may be taken.
        push_word(0, 32'hB); push_word(1, 32'hB); push_word(2, 32'h81);
        ser_en = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single words, SER_EN continuous (4'b1011 both orders, 8'h81)
        run(12, 0);

        // Stall: SER_EN every 3rd cycle; a second word offered mid-word
        push_word(0, 32'h6); push_word(1, 32'h6); push_word(2, 32'h66);
        run(4, 1);
        push_word(0, 32'hF); push_word(1, 32'hF); push_word(2, 32'hFF);
        run(60, 1);

        // Back-to-back with IN_VALID held
        push_word(0, 32'hA); push_word(1, 32'hA); push_word(2, 32'hA5);
        push_word(0, 32'h5); push_word(1, 32'h5); push_word(2, 32'h5A);
        run(24, 0);

        // Asynchronous reset mid-word, after two bits
        push_word(0, 32'hD); push_word(1, 32'hD); push_word(2, 32'hDD);
        run(3, 0);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        for (int l = 0; l < NL; l++) begin
            chk("arst_sout",   l, {31'd0, o_sout[l]},   32'd0);
            chk("arst_svalid", l, {31'd0, o_svalid[l]}, 32'd0);
            chk("arst_busy",   l, {31'd0, o_busy[l]},   32'd0);
            chk("arst_done",   l, {31'd0, o_done[l]},   32'd0);
            chk("arst_ready",  l, {31'd0, o_ready[l]},  32'd0);
            tx[l].delete();
        end
        @(negedge CLK);
        push_word(0, 32'h3); push_word(1, 32'h3); push_word(2, 32'h33);
        ser_en = 1'b1;
        step();
        rst = 1'b0;
        run(14, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < NL; l++) begin
                if ((tx[l].size() < 2) && ($urandom_range(0, 3) == 0)) push_word(l, $urandom);
            end
            rst    = ($urandom_range(0, 149) == 0);
            ser_en = ($urandom_range(0, 2) != 0);
            step();
        end
        rst = 1'b0;
        for (int l = 0; l < NL; l++) tx[l].delete();
        run(40, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
